// File: rtl/vit_pkg.sv
// Shared types and constants for the Viterbi BMC/ACS sequencing controller.
package vit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    RUN     = 2'd2,
    HANDOFF = 2'd3
  } state_e;

  localparam int FRAME_LEN_DEF = 64;
  localparam int PAIR_W        = 2;
  localparam int NUM_STATES    = 64;

endpackage

// File: rtl/vit_bank_tracker.sv
// Ping-pong survivor bank ownership: write bank, traceback bank and the
// traceback start/done bookkeeping.
import vit_pkg::*;

module vit_bank_tracker (
  input  logic clk,
  input  logic rst,
  input  logic handoff_req_i,
  input  logic tb_done_i,
  output logic tb_start_o,
  output logic tb_bank_o,
  output logic wbank_o,
  output logic tb_active_o
);

  logic wbank_q;
  logic tb_bank_q;
  logic tb_active_q;
  logic tb_active_d;

  // A finishing traceback frees its bank in the same cycle, so a waiting
  // handoff may start against it immediately.
  always_comb begin
    tb_start_o  = handoff_req_i & (~tb_active_q | tb_done_i);
    tb_active_d = tb_active_q;
    if (tb_start_o) begin
      tb_active_d = 1'b1;
    end else if (tb_done_i) begin
      tb_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      tb_bank_q   <= 1'b0;
      tb_active_q <= 1'b0;
    end else begin
      tb_active_q <= tb_active_d;
      if (tb_start_o) begin
        wbank_q   <= ~wbank_q;
        tb_bank_q <= wbank_q;
      end
    end
  end

  assign tb_bank_o   = tb_start_o ? wbank_q : tb_bank_q;
  assign wbank_o     = wbank_q;
  assign tb_active_o = tb_active_q;

endmodule

// File: rtl/vit_acs_ctrl.sv
// Viterbi BMC/ACS sequencing controller: frame FSM, step counter, survivor
// addressing. Optional path-metric normalisation under `VIT_PM_NORM_EN.
import vit_pkg::*;

module vit_acs_ctrl #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PAIR_W-1:0] in_pair,
  output logic              acs_en,
  output logic [PAIR_W-1:0] acs_pair,
  output logic              pm_init,
  output logic              sm_we,
  output logic [AW:0]       sm_waddr,
  output logic              tb_start,
  output logic              tb_bank,
  input  logic              tb_done,
`ifdef VIT_PM_NORM_EN
  input  logic              pm_msb_all,
  output logic              pm_norm,
`endif
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam logic [AW-1:0] LAST_STEP = AW'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      step_q, step_d;
  logic               acs_valid_q;
  logic [PAIR_W-1:0]  acs_pair_q;
  logic [AW-1:0]      acs_step_q;
  logic [15:0]        frame_cnt_q;
  logic               hs;
  logic               last_step_done;
  logic               wbank;
  logic               tb_active;

  assign hs             = in_valid & in_ready;
  assign last_step_done = acs_valid_q && (acs_step_q == LAST_STEP);

  // The cycle that drains the final step of a frame is still RUN but refuses
  // input, which gives the survivor write one cycle before traceback starts.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    pm_init  = 1'b0;
    unique case (state_q)
      IDLE:    state_d = INIT;
      INIT: begin
        pm_init = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        in_ready = ~last_step_done;
        if (last_step_done) state_d = HANDOFF;
      end
      HANDOFF: begin
        if (tb_start) state_d = INIT;
      end
    endcase
  end

  always_comb begin
    step_d = step_q;
    if (state_q == INIT) begin
      step_d = '0;
    end else if (hs) begin
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acs_valid_q <= 1'b0;
      acs_pair_q  <= '0;
      acs_step_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acs_valid_q <= hs;
      if (hs) begin
        acs_pair_q <= in_pair;
        acs_step_q <= step_q;
      end
      frame_cnt_q <= frame_cnt_q + 16'(tb_start);
    end
  end

  vit_bank_tracker u_bank_tracker (
    .clk           (clk),
    .rst           (rst),
    .handoff_req_i (state_q == HANDOFF),
    .tb_done_i     (tb_done),
    .tb_start_o    (tb_start),
    .tb_bank_o     (tb_bank),
    .wbank_o       (wbank),
    .tb_active_o   (tb_active)
  );

  assign acs_en    = acs_valid_q;
  assign sm_we     = acs_valid_q;
  assign acs_pair  = acs_valid_q ? acs_pair_q : '0;
  assign sm_waddr  = acs_valid_q ? {wbank, acs_step_q} : '0;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE) | tb_active;

`ifdef VIT_PM_NORM_EN
  assign pm_norm = acs_valid_q & pm_msb_all & ~pm_init;
`endif

endmodule

// File: tb/tb_vit_acs_ctrl.sv
// Randomized self-checking bench for vit_acs_ctrl against a frame-level
// reference model.
module tb_vit_acs_ctrl;

  localparam int FL = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_pair = 2'd0;
  logic          acs_en;
  logic [1:0]    acs_pair;
  logic          pm_init;
  logic          sm_we;
  logic [AW:0]   sm_waddr;
  logic          tb_start;
  logic          tb_bank;
  logic          tb_done = 1'b0;
  logic [15:0]   frame_cnt;
  logic          busy;
`ifdef VIT_PM_NORM_EN
  logic          pm_msb_all = 1'b0;
  logic          pm_norm;
`endif

  always #5 clk = ~clk;

  vit_acs_ctrl #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pair    (in_pair),
    .acs_en     (acs_en),
    .acs_pair   (acs_pair),
    .pm_init    (pm_init),
    .sm_we      (sm_we),
    .sm_waddr   (sm_waddr),
    .tb_start   (tb_start),
    .tb_bank    (tb_bank),
    .tb_done    (tb_done),
`ifdef VIT_PM_NORM_EN
    .pm_msb_all (pm_msb_all),
    .pm_norm    (pm_norm),
`endif
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: frame bookkeeping in terms of accepted pairs and banks.
  bit       mIdle;
  bit       mInitNow;
  bit       mAccepting;
  int       mAccCnt;
  bit       mDrain;
  bit       mWait;
  bit       mTbBusy;
  int       mWbank;
  int       mTbBank;
  int       mFrames;
  bit       mAccPrev;
  int       mPairPrev;
  int       mAddrPrev;
  bit       pairFresh = 1'b0;
  int       acsSeen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mIdle = 1; mInitNow = 0; mAccepting = 0; mAccCnt = 0; mDrain = 0;
    mWait = 0; mTbBusy = 0; mWbank = 0; mTbBank = 0; mFrames = 0;
    mAccPrev = 0; mPairPrev = 0; mAddrPrev = 0;
  endtask

  task automatic doReset(input int holdCycles);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; tb_done = 1'b0;
`ifdef VIT_PM_NORM_EN
    pm_msb_all = 1'b0;
`endif
    repeat (holdCycles) @(negedge clk);
    #1;
    checkOutput("rstReady", in_ready, 0);
    checkOutput("rstAcsEn", acs_en, 0);
    checkOutput("rstAcsPair", acs_pair, 0);
    checkOutput("rstPmInit", pm_init, 0);
    checkOutput("rstSmWe", sm_we, 0);
    checkOutput("rstWaddr", sm_waddr, 0);
    checkOutput("rstTbStart", tb_start, 0);
    checkOutput("rstTbBank", tb_bank, 0);
    checkOutput("rstFrameCnt", frame_cnt, 0);
    checkOutput("rstBusy", busy, 0);
`ifdef VIT_PM_NORM_EN
    checkOutput("rstPmNorm", pm_norm, 0);
`endif
    modelReset();
  endtask

  // doneMode < 0: pulse tb_done exactly on entry to a stalled handoff.
  // stopFrames > 0: return once the model has handed off that many frames.
  task automatic applyStimulus(input int nCycles, input int validPct, input int doneMode,
                               input int stopFrames);
    for (int c = 0; c < nCycles; c++) begin
      bit expReady, expStart, hs;
      int expBank;
      @(negedge clk);
      rst = 1'b0;
      if (pairFresh) begin
        in_pair   = 2'($urandom_range(3));
        pairFresh = 1'b0;
      end
      in_valid = ($urandom_range(99) < validPct);
      if (doneMode < 0) tb_done = mWait && mTbBusy;
      else              tb_done = ($urandom_range(99) < doneMode);
`ifdef VIT_PM_NORM_EN
      pm_msb_all = 1'($urandom_range(1));
`endif
      #1;
      expReady = mAccepting;
      expStart = mWait && (!mTbBusy || tb_done);
      expBank  = expStart ? mWbank : mTbBank;
      checkOutput("inReady", in_ready, expReady);
      checkOutput("acsEn", acs_en, mAccPrev);
      checkOutput("smWe", sm_we, mAccPrev);
      if (mAccPrev) begin
        checkOutput("acsPair", acs_pair, mPairPrev);
        checkOutput("smWaddr", sm_waddr, mAddrPrev);
      end
      checkOutput("pmInit", pm_init, mInitNow);
      checkOutput("tbStart", tb_start, expStart);
      checkOutput("tbBank", tb_bank, expBank);
      checkOutput("frameCnt", frame_cnt, mFrames);
      checkOutput("busy", busy, !mIdle || mTbBusy);
`ifdef VIT_PM_NORM_EN
      checkOutput("pmNorm", pm_norm, mAccPrev && pm_msb_all);
`endif
      if (acs_en) acsSeen++;

      hs        = expReady && in_valid;
      mAccPrev  = hs;
      mPairPrev = in_pair;
      mAddrPrev = mWbank * FL + mAccCnt;
      if (hs) pairFresh = 1'b1;
      if (expStart) begin
        mWait   = 0;
        mTbBank = mWbank;
        mWbank  = mWbank ^ 1;
        mFrames = (mFrames + 1) % 65536;
        mTbBusy = 1;
      end else if (tb_done) begin
        mTbBusy = 0;
      end
      if (mDrain) begin
        mDrain = 0;
        mWait  = 1;
      end
      if (hs) begin
        mAccCnt++;
        if (mAccCnt == FL) begin
          mAccepting = 0;
          mDrain     = 1;
        end
      end
      if (mInitNow) begin
        mAccepting = 1;
        mAccCnt    = 0;
      end
      mInitNow = expStart || mIdle;
      mIdle    = 0;
      if (stopFrames > 0 && mFrames >= stopFrames) break;
    end
  endtask

  initial begin
    int acsBase;
    modelReset();
    doReset(2);

    // Frame 0, continuous input, no traceback activity.
    applyStimulus(69, 100, 0, 0);
    checkOutput("frame0Cnt", frame_cnt, 1);

    // Frame 1 while traceback of frame 0 is still running: stall, then release.
    applyStimulus(66, 100, 0, 0);
    applyStimulus(9, 100, 0, 0);
    checkOutput("stallReady", in_ready, 0);
    checkOutput("stallCnt", frame_cnt, 1);
    applyStimulus(1, 100, 100, 0);
    applyStimulus(1, 100, 0, 0);
    checkOutput("frame1Cnt", frame_cnt, 2);

    // Three frames with random gaps and random traceback completion.
    doReset(1);
    acsBase = acsSeen;
    applyStimulus(3000, 50, 20, 3);
    applyStimulus(1, 50, 0, 0);
    checkOutput("rand3Frames", frame_cnt, 3);
    checkOutput("rand3Acs", acsSeen - acsBase, 3 * FL);

    // tb_done coincident with handoff entry; afterwards the bank must stay held.
    applyStimulus(3000, 80, -1, 6);
    applyStimulus(150, 100, 0, 0);

    // Reset mid-frame, then a clean frame from address 0.
    doReset(1);
    applyStimulus(32, 100, 0, 0);
    doReset(1);
    applyStimulus(70, 100, 0, 0);
    checkOutput("afterAbortCnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
